// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit bus CPU: data width, opcodes, control state encoding
// and the instruction field layout.
package cpu16_pkg;
  localparam int WIDTH = 16;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] rx;
    logic [2:0] ry;
  } instr_t;

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction
endpackage

// File: rtl/bus_mux.sv
// Combinational bus source select: one-hot sel over {din, G, R7..R0}; zero when nothing is selected.
module bus_mux #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic [NREGS*WIDTH-1:0] reg_q,
  input  logic [WIDTH-1:0]       g,
  input  logic [WIDTH-1:0]       din,
  input  logic [NREGS+1:0]       sel,
  output logic [WIDTH-1:0]       bus
);
  always_comb begin
    bus = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (sel[i]) bus = bus | reg_q[i*WIDTH +: WIDTH];
    end
    if (sel[NREGS])   bus = bus | g;
    if (sel[NREGS+1]) bus = bus | din;
  end
endmodule

// File: rtl/register_16bit.sv
// Load-enabled data register with synchronous active-high clear.
module register_16bit #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/bus_control_unit.sv
// Control FSM and datapath front end for the 16-bit bus CPU: sequences one instruction
// through T0..T3, holds IR/A/G and the add/sub ALU, and drives the bus and GP load enables.
module bus_control_unit
  import cpu16_pkg::*;
#(
  parameter int WIDTH = cpu16_pkg::WIDTH,
  parameter int NREGS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [8:0]             instr,
  input  logic [WIDTH-1:0]       din,
  input  logic [NREGS*WIDTH-1:0] reg_q,
  output logic [WIDTH-1:0]       buswires,
  output logic [NREGS-1:0]       rin,
  output logic                   done
);
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [8:0]       ir_q;
  instr_t           ir;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] g_q;
  logic [WIDTH-1:0] alu;
  logic [NREGS+1:0] sel;
  logic             ir_in;
  logic             a_in;
  logic             g_in;

  assign ir  = ir_q;
  assign alu = (ir.op == OP_SUB) ? a_q - buswires : a_q + buswires;

  register_16bit #(.W(9))     u_ir (.clk(clk), .reset(reset), .en(ir_in), .d(instr),    .q(ir_q));
  register_16bit #(.W(WIDTH)) u_a  (.clk(clk), .reset(reset), .en(a_in),  .d(buswires), .q(a_q));
  register_16bit #(.W(WIDTH)) u_g  (.clk(clk), .reset(reset), .en(g_in),  .d(alu),      .q(g_q));

  bus_mux #(.WIDTH(WIDTH), .NREGS(NREGS)) u_mux (
    .reg_q(reg_q),
    .g    (g_q),
    .din  (din),
    .sel  (sel),
    .bus  (buswires)
  );

  always_comb begin
    state_nxt = state;
    sel       = '0;
    rin       = '0;
    done      = 1'b0;
    ir_in     = 1'b0;
    a_in      = 1'b0;
    g_in      = 1'b0;
    case (state)
      T0: begin
        ir_in     = run;
        state_nxt = run ? T1 : T0;
      end
      T1: begin
        state_nxt = T0;
        case (ir.op)
          OP_MV: begin
            sel  = {2'b00, onehot8(ir.ry)};
            rin  = onehot8(ir.rx);
            done = 1'b1;
          end
          OP_MVI: begin
            sel  = {2'b10, 8'h00};
            rin  = onehot8(ir.rx);
            done = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            sel       = {2'b00, onehot8(ir.rx)};
            a_in      = 1'b1;
            state_nxt = T2;
          end
          default: done = 1'b1;
        endcase
      end
      T2: begin
        sel       = {2'b00, onehot8(ir.ry)};
        g_in      = 1'b1;
        state_nxt = T3;
      end
      default: begin
        sel       = {2'b01, 8'h00};
        rin       = onehot8(ir.rx);
        done      = 1'b1;
        state_nxt = T0;
      end
    endcase
    // Reset silences every output so an aborted instruction never writes its target.
    if (reset) begin
      sel       = '0;
      rin       = '0;
      done      = 1'b0;
      ir_in     = 1'b0;
      a_in      = 1'b0;
      g_in      = 1'b0;
      state_nxt = T0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= T0;
    else       state <= state_nxt;
  end
endmodule
